// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the misalignment rule used when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  // The reserved encoding 2'b11 behaves exactly like a word access.
  function automatic size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      default: return (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: merges store data into a fetched word and
// extracts/extends load data. Misaligned offsets are aligned down here.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] wdata,
  input  size_e             size,
  input  logic [1:0]        offset,
  input  logic              zero_ext,
  output logic [WORD_W-1:0] merged,
  output logic [WORD_W-1:0] rdata
);

  logic [1:0]        lane;
  logic [4:0]        shamt;
  logic [WORD_W-1:0] mask;
  logic [WORD_W-1:0] shifted;

  // Lane of the lowest byte touched; half and word drop the offending low bits.
  always_comb begin
    lane = 2'b00;
    case (size)
      SZ_BYTE: lane = offset;
      SZ_HALF: lane = {offset[1], 1'b0};
      default: lane = 2'b00;
    endcase
  end

  assign shamt = {lane, 3'b000};

  always_comb begin
    mask = '1;
    case (size)
      SZ_BYTE: mask = 32'h0000_00FF << shamt;
      SZ_HALF: mask = 32'h0000_FFFF << shamt;
      default: mask = '1;
    endcase
  end

  assign merged  = (word & ~mask) | ((wdata << shamt) & mask);
  assign shifted = word >> shamt;

  always_comb begin
    rdata = shifted;
    case (size)
      SZ_BYTE: rdata = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: IDLE/RD/WR/RESP FSM driving a word-wide memory port.
// Build option LSU_MISALIGN_TRAP_EN turns misaligned accesses into error responses.
module lsu
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE. rsp_valid is a one-cycle pulse the core
  // must take as-is (no backpressure).

  lsu_state_e        state;
  lsu_state_e        state_next;

  logic              we_q;
  size_e             size_q;
  logic              zext_q;
  logic              err_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] word_q;

  logic              accept;
  logic              trap_req;
  size_e             req_size_dec;
  logic [WORD_W-1:0] merged;
  logic [WORD_W-1:0] load_data;

  assign req_size_dec = decode_size(req_size);
  assign accept       = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_req = is_misaligned(req_size_dec, req_addr[1:0]);
`else
  assign trap_req = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (trap_req)
            state_next = ST_RESP;
          else if (req_we && (req_size_dec == SZ_WORD))
            state_next = ST_WR;
          else
            state_next = ST_RD;
        end
      end
      ST_RD:   state_next = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      zext_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size_dec;
        zext_q  <= req_unsigned;
        err_q   <= trap_req;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == ST_RD)
        word_q <= mem_rdata;
    end
  end

  lsu_align u_align (
    .word     (word_q),
    .wdata    (wdata_q),
    .size     (size_q),
    .offset   (addr_q[1:0]),
    .zero_ext (zext_q),
    .merged   (merged),
    .rdata    (load_data)
  );

  // Reset gates the strobe combinationally so an in-flight write is dropped.
  assign mem_we    = (state == ST_WR) && !reset;
  assign mem_addr  = {addr_q[WORD_W-1:2], 2'b00};
  assign mem_wdata = (state == ST_WR) ? merged : '0;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? load_data : '0;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized traffic
// checked against a byte-addressed reference memory.
module tb_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic [7:0]  ref_mem [1024];

  lsu dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // ---------------- clock / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    mem[a[9:2]] = v;
    for (int k = 0; k < 4; k++) ref_mem[{a[9:2], 2'b00} + k] = v[8*k +: 8];
  endtask

  task automatic init_mem;
    for (int w = 0; w < 256; w++) poke(w * 4, $urandom);
  endtask

  // Reference model: byte-granular memory, spec-level alignment and extension rules.
  function automatic void model_op(input logic we, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   output logic [31:0] rd, output logic err, output int lat);
    int n;
    int base;
    logic [31:0] v;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(a[9:0]);
    rd   = '0;
    err  = 1'b0;
    lat  = 0;
    if ((base % n) != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
      err = 1'b1;
`else
      base = base - (base % n);
`endif
    end
    if (err) begin
      lat = 1;
    end else if (we) begin
      for (int k = 0; k < n; k++) ref_mem[base + k] = wd[8*k +: 8];
      lat = (n == 4) ? 2 : 3;
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[base + k];
      if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rd  = v;
      lat = 2;
    end
  endfunction

  // Driver: issue one request, then watch up to 8 cycles for the response.
  task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat,
                       output int wecnt, output logic [31:0] wlast);
    rd = '0; err = 1'b0; lat = -1; wecnt = 0; wlast = '0;
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_we) begin wecnt++; wlast = mem_wdata; end
      if (rsp_valid) begin lat = k; rd = rsp_rdata; err = rsp_err; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready actual=%b required=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid actual=%b required=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata actual=%h required=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err actual=%b required=0", rsp_err); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we actual=%b required=0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr actual=%h required=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata actual=%h required=0", mem_wdata); end
    reset = 1'b0;
  endtask

  task automatic test_word_store_load;
    logic [31:0] rd, wl; logic err; int lat, wc;
    do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, err, lat, wc, wl);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency actual=%0d required=2", lat); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL sw_we_cycles actual=%0d required=1", wc); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem actual=%h required=deadbeef", mem[4]); end
    do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, err, lat, wc, wl);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata actual=%h required=deadbeef", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency actual=%0d required=2", lat); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL lw_we_cycles actual=%0d required=0", wc); end
  endtask

  task automatic test_byte_store;
    logic [31:0] rd, wl; logic err; int lat, wc;
    poke(32'h20, 32'h11223344);
    do_op(1'b1, 2'd0, 1'b0, 32'h21, 32'h123456AA, rd, err, lat, wc, wl);
    checks++; if (wl !== 32'h1122AA44) begin errors++; $display("FAIL sb_mem_wdata actual=%h required=1122aa44", wl); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency actual=%0d required=3", lat); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL sb_we_cycles actual=%0d required=1", wc); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sb_rsp_rdata actual=%h required=0", rd); end
  endtask

  task automatic test_load_extend;
    logic [31:0] rd, wl; logic err; int lat, wc;
    logic [31:0] exp_v [6];
    logic [31:0] addr_v [6];
    logic [1:0]  size_v [6];
    logic        uns_v [6];
    poke(32'h30, 32'h80FF7F01);
    addr_v = '{32'h32, 32'h32, 32'h32, 32'h30, 32'h31, 32'h30};
    size_v = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
    uns_v  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_v  = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01, 32'h0000007F, 32'h00007F01};
    for (int i = 0; i < 6; i++) begin
      do_op(1'b0, size_v[i], uns_v[i], addr_v[i], 32'h0, rd, err, lat, wc, wl);
      checks++;
      if (rd !== exp_v[i] || lat !== 2)
        begin errors++; $display("FAIL load_ext[%0d] actual=%h/lat%0d required=%h/lat2", i, rd, lat, exp_v[i]); end
    end
  endtask

  task automatic test_half_misalign;
    logic [31:0] rd, wl; logic err; int lat, wc;
    poke(32'h40, 32'h11223344);
    do_op(1'b1, 2'd1, 1'b0, 32'h41, 32'h0000BEEF, rd, err, lat, wc, wl);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (err !== 1'b1 || lat !== 1) begin errors++; $display("FAIL sh_mis_err actual=%b/lat%0d required=1/lat1", err, lat); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL sh_mis_we actual=%0d required=0", wc); end
    checks++; if (mem[16] !== 32'h11223344) begin errors++; $display("FAIL sh_mis_mem actual=%h required=11223344", mem[16]); end
`else
    checks++; if (err !== 1'b0 || lat !== 3) begin errors++; $display("FAIL sh_mis_err actual=%b/lat%0d required=0/lat3", err, lat); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL sh_mis_we actual=%0d required=1", wc); end
    checks++; if (mem[16] !== 32'h1122BEEF) begin errors++; $display("FAIL sh_mis_mem actual=%h required=1122beef", mem[16]); end
`endif
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sh_mis_rdata actual=%h required=0", rd); end
  endtask

  task automatic test_reset_mid_write;
    int wr_cyc = -1;
    int seen = 0;
    poke(32'h50, 32'h55667788);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h52; req_wdata = 32'h99;
    req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_we) begin wr_cyc = k; break; end
    end
    checks++; if (wr_cyc !== 2) begin errors++; $display("FAIL rst_wr_cycle actual=%0d required=2", wr_cyc); end
    reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we actual=%b required=0", mem_we); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready actual=%b required=1", req_ready); end
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_rsp_valid actual=%0d pulses required=0", seen); end
    checks++; if (mem[20] !== 32'h55667788) begin errors++; $display("FAIL rst_mem actual=%h required=55667788", mem[20]); end
  endtask

  task automatic test_random;
    logic [31:0] rd, wl, rd_e, a, wd; logic err, err_e, we, uns; logic [1:0] sz; int lat, wc, lat_e;
    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 1023));
      wd  = $urandom;
      model_op(we, sz, uns, a, wd, rd_e, err_e, lat_e);
      do_op(we, sz, uns, a, wd, rd, err, lat, wc, wl);
      checks++;
      if (rd !== rd_e || err !== err_e || lat !== lat_e || wc !== ((we && !err_e) ? 1 : 0))
        begin errors++; $display("FAIL random[%0d] we=%b sz=%0d a=%h actual=%h/%b/lat%0d/we%0d required=%h/%b/lat%0d",
                                 i, we, sz, a, rd, err, lat, wc, rd_e, err_e, lat_e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [32:0] exp_q[$];
    int          due_q[$];
    logic        we_a [8];
    logic [1:0]  sz_a [8];
    logic        uns_a [8];
    logic [31:0] addr_a [8];
    logic [31:0] wd_a [8];
    logic [31:0] rd_e; logic err_e; int lat_e;
    logic [32:0] e;
    int i = 0, got = 0, busy = 0, due;
    bit acc = 0;
    for (int k = 0; k < 8; k++) begin
      we_a[k]   = k[0];
      sz_a[k]   = 2'(k % 3);
      uns_a[k]  = 1'($urandom_range(0, 1));
      addr_a[k] = 32'($urandom_range(32'h100, 32'h10F));
      wd_a[k]   = $urandom;
    end
    @(negedge clk);
    req_we = we_a[0]; req_size = sz_a[0]; req_unsigned = uns_a[0]; req_addr = addr_a[0]; req_wdata = wd_a[0];
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (acc) begin
        i++;
        acc = 0;
        if (i < 8) begin
          req_we = we_a[i]; req_size = sz_a[i]; req_unsigned = uns_a[i]; req_addr = addr_a[i]; req_wdata = wd_a[i];
        end else req_valid = 1'b0;
      end
      if (busy > 0) begin
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy cyc=%0d actual=%b required=0", cyc, req_ready); end
        busy--;
      end else if (i < 8) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle cyc=%0d actual=%b required=1", cyc, req_ready); end
      end
      if (rsp_valid) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_rsp cyc=%0d actual=response required=none", cyc);
        end else begin
          e = exp_q.pop_front();
          due = due_q.pop_front();
          if ({rsp_err, rsp_rdata} !== e || cyc !== due)
            begin errors++; $display("FAIL b2b_rsp cyc=%0d actual=%b/%h required=%b/%h at cyc %0d", cyc, rsp_err, rsp_rdata, e[32], e[31:0], due); end
        end
      end
      if (req_valid && req_ready) begin
        model_op(we_a[i], sz_a[i], uns_a[i], addr_a[i], wd_a[i], rd_e, err_e, lat_e);
        exp_q.push_back({err_e, rd_e});
        due_q.push_back(cyc + lat_e);
        busy = lat_e;
        acc  = 1;
      end
    end
    req_valid = 1'b0;
    checks++; if (got !== 8 || exp_q.size() !== 0) begin errors++; $display("FAIL b2b_count actual=%0d pending=%0d required=8/0", got, exp_q.size()); end
  endtask

  task automatic test_mem_image;
    int bad = 0;
    logic [31:0] w;
    @(negedge clk);
    for (int k = 0; k < 256; k++) begin
      w = {ref_mem[4*k+3], ref_mem[4*k+2], ref_mem[4*k+1], ref_mem[4*k]};
      if (mem[k] !== w) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mem_image actual=%0d differing words required=0", bad); end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    init_mem();
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_load_extend();
    test_half_misalign();
    test_reset_mid_write();
    init_mem();
    test_random();
    test_back_to_back();
    test_mem_image();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
